// File: rtl/ascon_round_ctrl.sv
// ascon_round_ctrl: round sequencer for the ASCON permutation datapath.
// Takes a 6/8/12-round request, pulses a state load, then steps the
// round-constant index UNROLL rounds per cycle and reports completion.
// Optional macro ASCON_ROUND_CTRL_ABORT_EN adds an i_abort input that
// returns the controller to IDLE from any busy or done state.
module ascon_round_ctrl #(
   parameter int UNROLL        = 1,
   parameter int NB_ROUNDS_MAX = 12
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       i_start_valid,
   output logic       o_start_ready,
   input  logic [3:0] i_num_rounds,
`ifdef ASCON_ROUND_CTRL_ABORT_EN
   input  logic       i_abort,
`endif
   output logic       o_state_load,
   output logic       o_round_en,
   output logic [3:0] o_round_idx,
   output logic       o_busy,
   output logic       o_done_valid,
   output logic       o_done_error,
   input  logic       i_done_ready
);

   generate
      if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
         $error("ascon_round_ctrl: UNROLL must be 1 or 2");
      end
      if (NB_ROUNDS_MAX != 12) begin : g_bad_table
         $error("ascon_round_ctrl: NB_ROUNDS_MAX must be 12");
      end
   endgenerate

   localparam logic [3:0] IDX_STEP = 4'(UNROLL);
   localparam logic [3:0] IDX_END  = 4'd12;

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   state_t     state_q, state_d;
   logic [3:0] round_idx_q, round_idx_d;
   logic       state_load_q, state_load_d;
   logic       round_en_q, round_en_d;
   logic       busy_q, busy_d;
   logic       done_valid_q, done_valid_d;
   logic       done_error_q, done_error_d;
   logic       start_hs;
   logic       legal_cnt;
   logic       last_round;
   logic       abort_req;

   // Next-state, index and registered-output computation.
   always_comb begin
      state_d      = state_q;
      round_idx_d  = round_idx_q;
      done_error_d = done_error_q;
`ifdef ASCON_ROUND_CTRL_ABORT_EN
      abort_req    = i_abort;
`else
      abort_req    = 1'b0;
`endif
      start_hs   = i_start_valid && (state_q == IDLE);
      legal_cnt  = (i_num_rounds == 4'd6) || (i_num_rounds == 4'd8) ||
                   (i_num_rounds == 4'd12);
      // Index only steps in whole UNROLL strides, so the final stride lands exactly on 12.
      last_round = (round_idx_q + IDX_STEP) == IDX_END;

      case (state_q)
         IDLE: begin
            // Abort wins over a simultaneous request.
            if (start_hs && !abort_req) begin
               if (legal_cnt) begin
                  state_d     = LOAD;
                  round_idx_d = IDX_END - i_num_rounds;
               end else begin
                  state_d      = DONE;
                  done_error_d = 1'b1;
               end
            end
         end
         LOAD: state_d = RUN;
         RUN: begin
            if (last_round) state_d = DONE;
            else            round_idx_d = round_idx_q + IDX_STEP;
         end
         DONE: begin
            if (i_done_ready) begin
               state_d      = IDLE;
               done_error_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      if (abort_req && state_q != IDLE) begin
         state_d      = IDLE;
         round_idx_d  = 4'd0;
         done_error_d = 1'b0;
      end

      // Strobes reflect the state being entered, so they are valid from a flop.
      state_load_d = (state_d == LOAD);
      round_en_d   = (state_d == RUN);
      busy_d       = (state_d == LOAD) || (state_d == RUN);
      done_valid_d = (state_d == DONE);
   end

   // State and registered outputs; reset aborts everything immediately.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         round_idx_q  <= 4'd0;
         state_load_q <= 1'b0;
         round_en_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_valid_q <= 1'b0;
         done_error_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         round_idx_q  <= round_idx_d;
         state_load_q <= state_load_d;
         round_en_q   <= round_en_d;
         busy_q       <= busy_d;
         done_valid_q <= done_valid_d;
         done_error_q <= done_error_d;
      end
   end

   assign o_start_ready = (state_q == IDLE);
   assign o_state_load  = state_load_q;
   assign o_round_en    = round_en_q;
   assign o_round_idx   = round_idx_q;
   assign o_busy        = busy_q;
   assign o_done_valid  = done_valid_q;
   assign o_done_error  = done_error_q;

endmodule

// File: tb/tb_ascon_round_ctrl.sv
// Directed bench for ascon_round_ctrl: one instance with UNROLL=1 (index 0)
// and one with UNROLL=2 (index 1) share all inputs and are checked together.
module tb_ascon_round_ctrl;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       start_valid = 1'b0;
   logic [3:0] num = 4'd0;
   logic       done_ready = 1'b0;
   logic       abort = 1'b0;
   logic [1:0] s_rdy, s_load, s_en, s_busy, s_dv, s_de;
   logic [3:0] s_idx [2];
   int         errs = 0;
   int         checks = 0;

   always #5 clock = ~clock;

   ascon_round_ctrl #(.UNROLL(1)) u1 (
      .clock(clock), .reset_n(reset_n), .i_start_valid(start_valid),
      .o_start_ready(s_rdy[0]), .i_num_rounds(num),
`ifdef ASCON_ROUND_CTRL_ABORT_EN
      .i_abort(abort),
`endif
      .o_state_load(s_load[0]), .o_round_en(s_en[0]), .o_round_idx(s_idx[0]),
      .o_busy(s_busy[0]), .o_done_valid(s_dv[0]), .o_done_error(s_de[0]),
      .i_done_ready(done_ready));

   ascon_round_ctrl #(.UNROLL(2)) u2 (
      .clock(clock), .reset_n(reset_n), .i_start_valid(start_valid),
      .o_start_ready(s_rdy[1]), .i_num_rounds(num),
`ifdef ASCON_ROUND_CTRL_ABORT_EN
      .i_abort(abort),
`endif
      .o_state_load(s_load[1]), .o_round_en(s_en[1]), .o_round_idx(s_idx[1]),
      .o_busy(s_busy[1]), .o_done_valid(s_dv[1]), .o_done_error(s_de[1]),
      .i_done_ready(done_ready));

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Bounded wait for both instances to raise done_valid.
   task automatic wait_done();
      int n;
      n = 0;
      while (s_dv !== 2'b11 && n < 30) begin
         step();
         n++;
      end
      checks++;
      if (s_dv !== 2'b11) begin
         errs++;
         $display("FAIL wait_done timeout: dv=%b want 11", s_dv);
      end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({s_load, s_en, s_busy, s_dv, s_de} !== 10'b0 || s_rdy !== 2'b11) begin
         errs++;
         $display("FAIL reset_outputs: load=%b en=%b busy=%b dv=%b de=%b rdy=%b", s_load, s_en, s_busy, s_dv, s_de, s_rdy);
      end
      checks++;
      if (s_idx[0] !== 4'd0 || s_idx[1] !== 4'd0) begin
         errs++;
         $display("FAIL reset_idx: got %0d/%0d want 0/0", s_idx[0], s_idx[1]);
      end
      step();
      step();
      reset_n = 1'b1;
      step();
   endtask

   // Full legal permutation, cycle by cycle, against the latency model.
   task automatic test_legal(input int n);
      start_valid = 1'b1;
      num = 4'(n);
      checks++;
      if (s_rdy !== 2'b11) begin
         errs++;
         $display("FAIL legal%0d_start_ready: got %b want 11", n, s_rdy);
      end
      for (int k = 1; k <= 2 + n; k++) begin
         step();
         if (k == 1) start_valid = 1'b0;
         for (int d = 0; d < 2; d++) begin
            int u;
            int r;
            logic e_load, e_en, e_dv;
            logic [3:0] e_idx;
            u = d + 1;
            r = n / u;
            e_load = (k == 1);
            e_en = (k >= 2) && (k <= 1 + r);
            e_dv = (k >= 2 + r);
            e_idx = (k == 1) ? 4'(12 - n) : (e_en ? 4'(12 - n + (k - 2) * u) : 4'(12 - u));
            checks++;
            if ({s_load[d], s_en[d], s_dv[d], s_de[d], s_busy[d]} !== {e_load, e_en, e_dv, 1'b0, e_load | e_en}) begin
               errs++;
               $display("FAIL legal%0d_strobes dut%0d cyc%0d: load/en/dv/de/busy=%b%b%b%b%b want %b%b%b0%b",
                        n, d, k, s_load[d], s_en[d], s_dv[d], s_de[d], s_busy[d], e_load, e_en, e_dv, e_load | e_en);
            end
            checks++;
            if (s_idx[d] !== e_idx) begin
               errs++;
               $display("FAIL legal%0d_idx dut%0d cyc%0d: got %0d want %0d", n, d, k, s_idx[d], e_idx);
            end
         end
      end
      done_ready = 1'b1;
      step();
      done_ready = 1'b0;
      checks++;
      if (s_dv !== 2'b00 || s_rdy !== 2'b11) begin
         errs++;
         $display("FAIL legal%0d_release: dv=%b rdy=%b want 00/11", n, s_dv, s_rdy);
      end
   endtask

   task automatic test_backpressure();
      start_valid = 1'b1;
      num = 4'd6;
      step();
      start_valid = 1'b0;
      wait_done();
      start_valid = 1'b1;
      num = 4'd8;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (s_dv !== 2'b11 || s_rdy !== 2'b00 || s_load !== 2'b00) begin
            errs++;
            $display("FAIL bp_hold cyc%0d: dv=%b rdy=%b load=%b want 11/00/00", i, s_dv, s_rdy, s_load);
         end
      end
      done_ready = 1'b1;
      step();
      done_ready = 1'b0;
      checks++;
      if (s_rdy !== 2'b11 || s_dv !== 2'b00 || s_load !== 2'b00) begin
         errs++;
         $display("FAIL bp_release: rdy=%b dv=%b load=%b want 11/00/00", s_rdy, s_dv, s_load);
      end
      step();
      start_valid = 1'b0;
      checks++;
      if (s_load !== 2'b11 || s_idx[0] !== 4'd4 || s_idx[1] !== 4'd4) begin
         errs++;
         $display("FAIL bp_pending_start: load=%b idx=%0d/%0d want 11 4/4", s_load, s_idx[0], s_idx[1]);
      end
      wait_done();
      done_ready = 1'b1;
      step();
      done_ready = 1'b0;
   endtask

   task automatic test_illegal();
      int bad [4] = '{7, 0, 15, 10};
      for (int i = 0; i < 4; i++) begin
         start_valid = 1'b1;
         num = 4'(bad[i]);
         step();
         start_valid = 1'b0;
         for (int c = 0; c < 2; c++) begin
            checks++;
            if (s_dv !== 2'b11 || s_de !== 2'b11 || s_load !== 2'b00 || s_en !== 2'b00 || s_busy !== 2'b00) begin
               errs++;
               $display("FAIL illegal%0d cyc%0d: dv=%b de=%b load=%b en=%b busy=%b want 11/11/00/00/00",
                        bad[i], c, s_dv, s_de, s_load, s_en, s_busy);
            end
            if (c == 0) step();
         end
         done_ready = 1'b1;
         step();
         done_ready = 1'b0;
         checks++;
         if (s_dv !== 2'b00 || s_de !== 2'b00 || s_rdy !== 2'b11) begin
            errs++;
            $display("FAIL illegal%0d_release: dv=%b de=%b rdy=%b want 00/00/11", bad[i], s_dv, s_de, s_rdy);
         end
      end
   endtask

   task automatic test_reset_mid_run();
      start_valid = 1'b1;
      num = 4'd12;
      step();
      start_valid = 1'b0;
      repeat (4) step();
      checks++;
      if (s_en[0] !== 1'b1 || s_idx[0] !== 4'd3) begin
         errs++;
         $display("FAIL midrun_pre: en=%b idx=%0d want 1/3", s_en[0], s_idx[0]);
      end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({s_load, s_en, s_busy, s_dv, s_de} !== 10'b0 || s_rdy !== 2'b11 || s_idx[0] !== 4'd0 || s_idx[1] !== 4'd0) begin
         errs++;
         $display("FAIL midrun_reset: load=%b en=%b busy=%b dv=%b de=%b rdy=%b idx=%0d/%0d",
                  s_load, s_en, s_busy, s_dv, s_de, s_rdy, s_idx[0], s_idx[1]);
      end
      #1 reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (s_dv !== 2'b00 || s_en !== 2'b00 || s_rdy !== 2'b11) begin
            errs++;
            $display("FAIL midrun_after cyc%0d: dv=%b en=%b rdy=%b want 00/00/11", i, s_dv, s_en, s_rdy);
         end
      end
   endtask

`ifdef ASCON_ROUND_CTRL_ABORT_EN
   task automatic test_abort();
      start_valid = 1'b1;
      num = 4'd12;
      step();
      start_valid = 1'b0;
      repeat (6) step();
      checks++;
      if (s_idx[0] !== 4'd5) begin
         errs++;
         $display("FAIL abort_pre: idx=%0d want 5", s_idx[0]);
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
      checks++;
      if ({s_load, s_en, s_busy, s_dv, s_de} !== 10'b0 || s_rdy !== 2'b11 || s_idx[0] !== 4'd0 || s_idx[1] !== 4'd0) begin
         errs++;
         $display("FAIL abort_run: load=%b en=%b busy=%b dv=%b de=%b rdy=%b idx=%0d/%0d",
                  s_load, s_en, s_busy, s_dv, s_de, s_rdy, s_idx[0], s_idx[1]);
      end
      abort = 1'b1;
      start_valid = 1'b1;
      step();
      abort = 1'b0;
      start_valid = 1'b0;
      checks++;
      if (s_load !== 2'b00 || s_rdy !== 2'b11) begin
         errs++;
         $display("FAIL abort_idle_priority: load=%b rdy=%b want 00/11", s_load, s_rdy);
      end
      step();
      checks++;
      if (s_load !== 2'b00 || s_en !== 2'b00 || s_dv !== 2'b00) begin
         errs++;
         $display("FAIL abort_idle_after: load=%b en=%b dv=%b want 00/00/00", s_load, s_en, s_dv);
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_legal(12);
      test_legal(6);
      test_legal(8);
      test_backpressure();
      test_illegal();
      test_reset_mid_run();
`ifdef ASCON_ROUND_CTRL_ABORT_EN
      test_abort();
`endif
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
